// File: rtl/dm_stage_mem_pkg.sv
// Shared definitions for the M-stage data memory: opcodes, access kinds and decoders.
// Opcode values match the ones used by the decoders in the other pipeline stages.
package dm_stage_mem_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_W    = 3'd1,
        LD_H    = 3'd2,
        LD_HU   = 3'd3,
        LD_B    = 3'd4,
        LD_BU   = 3'd5
    } ld_kind_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_W    = 2'd1,
        ST_H    = 2'd2,
        ST_B    = 2'd3
    } st_kind_e;

    function automatic ld_kind_e decode_load(input logic [5:0] op);
        ld_kind_e k;
        case (op)
            OP_LW:   k = LD_W;
            OP_LH:   k = LD_H;
            OP_LHU:  k = LD_HU;
            OP_LB:   k = LD_B;
            OP_LBU:  k = LD_BU;
            default: k = LD_NONE;
        endcase
        return k;
    endfunction

    function automatic st_kind_e decode_store(input logic [5:0] op);
        st_kind_e k;
        case (op)
            OP_SW:   k = ST_W;
            OP_SH:   k = ST_H;
            OP_SB:   k = ST_B;
            default: k = ST_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/dm_stage_mem_ext.sv
// Load lane select and sign/zero extension (combinational).
// Little-endian lanes: addr 0 selects bits [7:0], halfword addr[1]=0 selects [15:0].
module dm_ext
    import dm_stage_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  kind,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the word.
    always_comb begin
        byte_s = 8'd0;
        half_s = 16'd0;
        case (addr)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'd0;
        endcase
        if (addr[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane according to the load kind.
    always_comb begin
        result = 32'd0;
        case (ld_kind_e'(kind))
            LD_W:    result = word;
            LD_H:    result = {{16{half_s[15]}}, half_s};
            LD_HU:   result = {16'd0, half_s};
            LD_B:    result = {{24{byte_s[7]}}, byte_s};
            LD_BU:   result = {24'd0, byte_s};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/dm_stage_mem.sv
// M-stage data memory: word-organised RAM with byte/half/word stores, extended loads,
// registered W-stage load data, error flag and a store-trace record.
module dm_stage_mem
    import dm_stage_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M_in,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] RT_M_in,
    input  logic [31:0] PC4_M_in,
    output logic [31:0] DMout_W,
    output logic        addr_err,
    output logic        wr_valid,
    output logic [31:0] wr_pc,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data
);

    localparam logic [32:0] RANGE_BYTES = 33'(4 * DEPTH_WORDS);

    logic [31:0]   mem_r [DEPTH_WORDS];
    logic [5:0]    op_s;
    ld_kind_e      ld_kind_s;
    st_kind_e      st_kind_s;
    logic          is_load_s;
    logic          is_store_s;
    logic          misalign_s;
    logic          out_of_range_s;
    logic          err_s;
    logic          wr_en_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   ld_data_s;
    logic [31:0]   merged_s;
    logic          unused_instr_bits_s;

    assign op_s                = Instr_M_in[31:26];
    assign unused_instr_bits_s = ^Instr_M_in[25:0];
    assign ld_kind_s           = decode_load(op_s);
    assign st_kind_s           = decode_store(op_s);
    assign is_load_s           = (ld_kind_s != LD_NONE);
    assign is_store_s          = (st_kind_s != ST_NONE);
    assign idx_s               = ALUout_M[AW+1:2];
    assign rd_word_s           = mem_r[idx_s];

    // Alignment and range check; only meaningful for real memory accesses.
    always_comb begin
        misalign_s = 1'b0;
        if ((ld_kind_s == LD_W) || (st_kind_s == ST_W)) begin
            misalign_s = (ALUout_M[1:0] != 2'b00);
        end else if ((ld_kind_s == LD_H) || (ld_kind_s == LD_HU) || (st_kind_s == ST_H)) begin
            misalign_s = ALUout_M[0];
        end else begin
            misalign_s = 1'b0;
        end
    end

    assign out_of_range_s = ({1'b0, ALUout_M} >= RANGE_BYTES);
    assign err_s          = (is_load_s || is_store_s) && (misalign_s || out_of_range_s);
    assign wr_en_s        = is_store_s && !err_s;

    // Byte-merge of the store data into the currently held word.
    always_comb begin
        merged_s = rd_word_s;
        case (st_kind_s)
            ST_W: merged_s = RT_M_in;
            ST_H: begin
                if (ALUout_M[1]) begin
                    merged_s[31:16] = RT_M_in[15:0];
                end else begin
                    merged_s[15:0] = RT_M_in[15:0];
                end
            end
            ST_B: begin
                case (ALUout_M[1:0])
                    2'd0:    merged_s[7:0]   = RT_M_in[7:0];
                    2'd1:    merged_s[15:8]  = RT_M_in[7:0];
                    2'd2:    merged_s[23:16] = RT_M_in[7:0];
                    2'd3:    merged_s[31:24] = RT_M_in[7:0];
                    default: merged_s        = rd_word_s;
                endcase
            end
            default: merged_s = rd_word_s;
        endcase
    end

    dm_ext u_ext (
        .word   (rd_word_s),
        .addr   (ALUout_M[1:0]),
        .kind   (ld_kind_s),
        .result (ld_data_s)
    );

    // RAM array: cleared on reset, which also suppresses a simultaneous store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // W-stage load result and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            DMout_W  <= 32'd0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= err_s;
            if (is_load_s && !err_s) begin
                DMout_W <= ld_data_s;
            end else begin
                DMout_W <= 32'd0;
            end
        end
    end

    // Store trace: fields hold their last value between committed stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_pc    <= 32'd0;
            wr_addr  <= 32'd0;
            wr_data  <= 32'd0;
        end else begin
            wr_valid <= wr_en_s;
            if (wr_en_s) begin
                wr_pc   <= PC4_M_in - 32'd4;
                wr_addr <= {ALUout_M[31:2], 2'b00};
                wr_data <= merged_s;
            end
        end
    end

endmodule

// File: tb/tb_dm_stage_mem.sv
// Directed self-checking bench for dm_stage_mem with hand-computed expectations.
module tb_dm_stage_mem;
    import dm_stage_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] Instr_M_in;
    logic [31:0] ALUout_M;
    logic [31:0] RT_M_in;
    logic [31:0] PC4_M_in;
    logic [31:0] DMout_W;
    logic        addr_err;
    logic        wr_valid;
    logic [31:0] wr_pc;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    dm_stage_mem dut (
        .clk        (clk),
        .reset      (reset),
        .Instr_M_in (Instr_M_in),
        .ALUout_M   (ALUout_M),
        .RT_M_in    (RT_M_in),
        .PC4_M_in   (PC4_M_in),
        .DMout_W    (DMout_W),
        .addr_err   (addr_err),
        .wr_valid   (wr_valid),
        .wr_pc      (wr_pc),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction in M for one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic cyc(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] pc4);
        Instr_M_in = {op, 26'h0000123};
        ALUout_M   = addr;
        RT_M_in    = rt;
        PC4_M_in   = pc4;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(6'd0, 32'd0, 32'd0, 32'd0);
        cyc(6'd0, 32'd0, 32'd0, 32'd0);
        checks++;
        if ({DMout_W, addr_err, wr_valid, wr_pc, wr_addr, wr_data} !== 130'd0) begin
            errors++;
            $display("FAIL reset_outputs: got dm=%h err=%b wv=%b pc=%h a=%h d=%h, want all zero",
                     DMout_W, addr_err, wr_valid, wr_pc, wr_addr, wr_data);
        end
        reset = 1'b0;
        cyc(OP_LW, 32'h0, 32'd0, 32'h0000_0004);
        checks++;
        if (DMout_W !== 32'h0 || addr_err !== 1'b0 || wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_after_reset: got dm=%h err=%b wv=%b, want 0 0 0", DMout_W, addr_err, wr_valid);
        end
    endtask

    task automatic test_word();
        cyc(OP_SW, 32'h10, 32'h1234_5678, 32'h0000_0104);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 32'h10 || wr_data !== 32'h1234_5678 || wr_pc !== 32'h100) begin
            errors++;
            $display("FAIL sw_trace: got wv=%b a=%h d=%h pc=%h, want 1 00000010 12345678 00000100",
                     wr_valid, wr_addr, wr_data, wr_pc);
        end
        cyc(OP_LW, 32'h10, 32'd0, 32'h0000_0108);
        checks++;
        if (DMout_W !== 32'h1234_5678 || wr_valid !== 1'b0 || wr_addr !== 32'h10) begin
            errors++;
            $display("FAIL lw_word: got dm=%h wv=%b a=%h, want 12345678 0 00000010", DMout_W, wr_valid, wr_addr);
        end
    endtask

    task automatic test_byte();
        cyc(OP_SB, 32'h12, 32'hFFFF_FFAB, 32'h0000_0200);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 32'h10 || wr_data !== 32'h12AB_5678) begin
            errors++;
            $display("FAIL sb_trace: got wv=%b a=%h d=%h, want 1 00000010 12ab5678", wr_valid, wr_addr, wr_data);
        end
        cyc(OP_LB, 32'h12, 32'd0, 32'h0000_0204);
        checks++;
        if (DMout_W !== 32'hFFFF_FFAB) begin
            errors++;
            $display("FAIL lb_sign: got %h, want ffffffab", DMout_W);
        end
        cyc(OP_LBU, 32'h12, 32'd0, 32'h0000_0208);
        checks++;
        if (DMout_W !== 32'h0000_00AB) begin
            errors++;
            $display("FAIL lbu_zero: got %h, want 000000ab", DMout_W);
        end
    endtask

    task automatic test_half();
        cyc(OP_SH, 32'h16, 32'hCCCC_8001, 32'h0000_0304);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 32'h14 || wr_data !== 32'h8001_0000 || wr_pc !== 32'h300) begin
            errors++;
            $display("FAIL sh_trace: got wv=%b a=%h d=%h pc=%h, want 1 00000014 80010000 00000300",
                     wr_valid, wr_addr, wr_data, wr_pc);
        end
        cyc(OP_LH, 32'h16, 32'd0, 32'h0000_0308);
        checks++;
        if (DMout_W !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh_sign: got %h, want ffff8001", DMout_W);
        end
        cyc(OP_LHU, 32'h16, 32'd0, 32'h0000_030C);
        checks++;
        if (DMout_W !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu_zero: got %h, want 00008001", DMout_W);
        end
        cyc(OP_LH, 32'h14, 32'd0, 32'h0000_0310);
        checks++;
        if (DMout_W !== 32'h0) begin
            errors++;
            $display("FAIL lh_low_half: got %h, want 00000000", DMout_W);
        end
    endtask

    task automatic test_errors();
        cyc(OP_LW, 32'h11, 32'd0, 32'h0000_0404);
        checks++;
        if (addr_err !== 1'b1 || DMout_W !== 32'h0) begin
            errors++;
            $display("FAIL lw_misaligned: got err=%b dm=%h, want 1 00000000", addr_err, DMout_W);
        end
        cyc(OP_SH, 32'h13, 32'h0000_DEAD, 32'h0000_0408);
        checks++;
        if (addr_err !== 1'b1 || wr_valid !== 1'b0 || DMout_W !== 32'h0) begin
            errors++;
            $display("FAIL sh_misaligned: got err=%b wv=%b dm=%h, want 1 0 00000000", addr_err, wr_valid, DMout_W);
        end
        cyc(OP_LW, 32'h10, 32'd0, 32'h0000_040C);
        checks++;
        if (DMout_W !== 32'h12AB_5678 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reread_after_sh_err: got dm=%h err=%b, want 12ab5678 0", DMout_W, addr_err);
        end
        cyc(OP_SW, 32'h4000, 32'hDEAD_BEEF, 32'h0000_0410);
        checks++;
        if (addr_err !== 1'b1 || wr_valid !== 1'b0 || wr_addr !== 32'h14) begin
            errors++;
            $display("FAIL sw_out_of_range: got err=%b wv=%b a=%h, want 1 0 00000014", addr_err, wr_valid, wr_addr);
        end
        cyc(OP_LW, 32'h0, 32'd0, 32'h0000_0414);
        checks++;
        if (DMout_W !== 32'h0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reread_word0_after_oor: got dm=%h err=%b, want 00000000 0", DMout_W, addr_err);
        end
        cyc(OP_LW, 32'h3FFC, 32'd0, 32'h0000_0418);
        checks++;
        if (DMout_W !== 32'h0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL lw_last_word: got dm=%h err=%b, want 00000000 0", DMout_W, addr_err);
        end
        cyc(OP_LBU, 32'h4000, 32'd0, 32'h0000_041C);
        checks++;
        if (addr_err !== 1'b1 || DMout_W !== 32'h0) begin
            errors++;
            $display("FAIL lbu_out_of_range: got err=%b dm=%h, want 1 00000000", addr_err, DMout_W);
        end
        cyc(6'b000000, 32'h11, 32'd0, 32'h0000_0420);
        checks++;
        if (addr_err !== 1'b0 || DMout_W !== 32'h0) begin
            errors++;
            $display("FAIL nop_no_err: got err=%b dm=%h, want 0 00000000", addr_err, DMout_W);
        end
    endtask

    task automatic test_back_to_back();
        cyc(OP_SW, 32'h30, 32'h1122_3344, 32'h0000_0504);
        cyc(OP_LW, 32'h30, 32'd0, 32'h0000_0508);
        checks++;
        if (DMout_W !== 32'h1122_3344) begin
            errors++;
            $display("FAIL store_then_load: got %h, want 11223344", DMout_W);
        end
        cyc(OP_LB, 32'h33, 32'd0, 32'h0000_050C);
        checks++;
        if (DMout_W !== 32'h0000_0011) begin
            errors++;
            $display("FAIL lb_lane3: got %h, want 00000011", DMout_W);
        end
        cyc(OP_LH, 32'h32, 32'd0, 32'h0000_0510);
        checks++;
        if (DMout_W !== 32'h0000_1122) begin
            errors++;
            $display("FAIL lh_upper: got %h, want 00001122", DMout_W);
        end
        cyc(OP_LBU, 32'h31, 32'd0, 32'h0000_0514);
        checks++;
        if (DMout_W !== 32'h0000_0033) begin
            errors++;
            $display("FAIL lbu_lane1: got %h, want 00000033", DMout_W);
        end
        cyc(OP_SB, 32'h30, 32'h0000_0080, 32'h0000_0518);
        cyc(OP_LB, 32'h30, 32'd0, 32'h0000_051C);
        checks++;
        if (DMout_W !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL sb_then_lb: got %h, want ffffff80", DMout_W);
        end
    endtask

    task automatic test_reset_store();
        reset = 1'b1;
        cyc(OP_SW, 32'h20, 32'hFFFF_FFFF, 32'h0000_0604);
        checks++;
        if (wr_valid !== 1'b0 || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL sw_during_reset: got wv=%b d=%h, want 0 00000000", wr_valid, wr_data);
        end
        reset = 1'b0;
        cyc(OP_LW, 32'h20, 32'd0, 32'h0000_0608);
        checks++;
        if (DMout_W !== 32'h0 || wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_after_reset_store: got dm=%h wv=%b, want 00000000 0", DMout_W, wr_valid);
        end
        cyc(OP_LW, 32'h10, 32'd0, 32'h0000_060C);
        checks++;
        if (DMout_W !== 32'h0) begin
            errors++;
            $display("FAIL ram_cleared: got %h, want 00000000", DMout_W);
        end
        cyc(OP_LW, 32'h10, 32'd0, 32'h0000_0610);
        reset = 1'b1;
        cyc(OP_LW, 32'h30, 32'd0, 32'h0000_0614);
        checks++;
        if (DMout_W !== 32'h0) begin
            errors++;
            $display("FAIL load_during_reset: got %h, want 00000000", DMout_W);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        Instr_M_in = 32'd0;
        ALUout_M   = 32'd0;
        RT_M_in    = 32'd0;
        PC4_M_in   = 32'd0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
